// File: rtl/drum_pad_irq_arbiter.sv
// Shares one CPU interrupt line between NUM_PADS drum-pad triggers.
// Each pad is synchronized, edge-detected and rate-limited; accepted hits are pended and granted round-robin.
module drum_pad_irq_arbiter #(
    parameter int                   NUM_PADS        = 4,
    parameter int                   HOLDOFF_W       = 16,
    parameter logic [HOLDOFF_W-1:0] DEFAULT_HOLDOFF = 16'd50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_PADS-1:0] pad_in,
    output logic                irq
);

    localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    typedef enum logic {
        S_IDLE,
        S_GRANTED
    } arbState_t;

    logic                 w_write;
    logic                 w_unusedWrData;
    logic [NUM_PADS-1:0]  r_sync1;
    logic [NUM_PADS-1:0]  r_sync2;
    logic [NUM_PADS-1:0]  r_sync2d;
    logic [NUM_PADS-1:0]  w_edge;
    logic [NUM_PADS-1:0]  w_accept;
    logic [NUM_PADS-1:0]  w_clear;
    logic [NUM_PADS-1:0]  w_request;
    logic [NUM_PADS-1:0]  r_pending;
    logic [NUM_PADS-1:0]  r_mask;
    logic [HOLDOFF_W-1:0] r_holdoff;
    logic [HOLDOFF_W-1:0] r_holdoffCnt [NUM_PADS];
    logic                 r_irq;
    logic [31:0]          r_readdata;
    logic [31:0]          w_readWord;
    arbState_t            r_state;
    logic                 r_grantValid;
    logic [IDX_W-1:0]     r_grantIdx;
    logic [IDX_W-1:0]     r_lastIdx;
    logic [IDX_W-1:0]     w_pickIdx;
    logic                 w_pickFound;

    assign w_write        = chipselect & ~write_n;
    assign w_unusedWrData = ^writedata;
    assign w_edge         = r_sync2 & ~r_sync2d;
    assign w_request      = r_pending & r_mask;
    assign w_clear        = (w_write && address == 2'd0) ? writedata[NUM_PADS-1:0] : '0;
    assign irq            = r_irq;
    assign readdata       = r_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync2d <= '0;
        end else begin
            r_sync1  <= pad_in;
            r_sync2  <= r_sync1;
            r_sync2d <= r_sync2;
        end
    end

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            w_accept[i] = w_edge[i] && (r_holdoffCnt[i] == '0);
        end
    end

    // A counter only reloads on an accepted edge; rejected edges keep it counting down.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                r_holdoffCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
                if (w_accept[i]) begin
                    r_holdoffCnt[i] <= r_holdoff;
                end else if (r_holdoffCnt[i] != '0) begin
                    r_holdoffCnt[i] <= r_holdoffCnt[i] - HOLDOFF_W'(1);
                end
            end
        end
    end

    // OR-ing the accept after the clear lets a new hit win over a same-cycle W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_holdoff <= DEFAULT_HOLDOFF;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_accept;
            if (w_write && address == 2'd1) begin
                r_mask <= writedata[NUM_PADS-1:0];
            end
            if (w_write && address == 2'd3) begin
                r_holdoff <= writedata[HOLDOFF_W-1:0];
            end
            r_irq <= |w_request;
        end
    end

    always_comb begin
        int cand;
        cand        = 0;
        w_pickFound = 1'b0;
        w_pickIdx   = '0;
        for (int off = 0; off < NUM_PADS; off++) begin
            cand = int'(r_lastIdx) + 1 + off;
            if (cand >= NUM_PADS) begin
                cand = cand - NUM_PADS;
            end
            if (!w_pickFound && w_request[IDX_W'(cand)]) begin
                w_pickFound = 1'b1;
                w_pickIdx   = IDX_W'(cand);
            end
        end
    end

    // Releasing a grant always passes through IDLE, giving a one-cycle gap before the next grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_grantValid <= 1'b0;
            r_grantIdx   <= '0;
            r_lastIdx    <= IDX_W'(NUM_PADS - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pickFound) begin
                        r_grantIdx   <= w_pickIdx;
                        r_lastIdx    <= w_pickIdx;
                        r_grantValid <= 1'b1;
                        r_state      <= S_GRANTED;
                    end
                end
                S_GRANTED: begin
                    if (!r_pending[r_grantIdx] || !r_mask[r_grantIdx]) begin
                        r_grantValid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_grantValid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_readWord = '0;
        case (address)
            2'd0: w_readWord[NUM_PADS-1:0] = r_pending;
            2'd1: w_readWord[NUM_PADS-1:0] = r_mask;
            2'd2: begin
                w_readWord[31]        = r_grantValid;
                w_readWord[IDX_W-1:0] = r_grantIdx;
            end
            2'd3: w_readWord[HOLDOFF_W-1:0] = r_holdoff;
            default: w_readWord = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_readWord;
        end
    end

endmodule
